// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// States, command-byte layout and width defaults.
package spi_ctrl_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int CMD_RW_BIT = 7;
  localparam logic [7:0] DUMMY_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_WAIT,
    RD_STREAM,
    WR_STREAM,
    DROP
  } state_t;

endpackage

// File: rtl/spi_reg_controller.sv
// SPI byte stream to register-file bridge: command byte, then
// auto-incrementing read or write burst until chip select drops.
module spi_reg_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter int         DATA_W = DATA_W_DEF,
  parameter logic [7:0] DUMMY  = DUMMY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              err_overrun
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_n;
  logic              cs_prev;
  logic [7:0]        tx_byte_n;
  logic              tx_load_n;
  logic [ADDR_W-1:0] reg_addr_n;
  logic              reg_wr_en_n;
  logic [DATA_W-1:0] reg_wdata_n;
  logic              reg_rd_en_n;
  logic              err_n;
  logic              cs_rise;
  logic              rx_ok;

  // Bytes only count while the transaction is open.
  assign cs_rise = cs_active & ~cs_prev;
  assign rx_ok   = rx_valid & cs_active;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    tx_byte_n   = tx_byte;
    tx_load_n   = 1'b0;
    reg_addr_n  = reg_addr;
    reg_wr_en_n = 1'b0;
    reg_wdata_n = reg_wdata;
    reg_rd_en_n = 1'b0;
    err_n       = err_overrun;
    if (state != IDLE && !cs_active) begin
      state_n = IDLE;
    end else if (state != IDLE && cs_rise) begin
      state_n = DROP;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_rise) begin
            state_n   = CMD;
            tx_byte_n = DUMMY;
            tx_load_n = 1'b1;
            err_n     = 1'b0;
          end
        end
        CMD: begin
          if (rx_ok) begin
            addr_n = ADDR_W'(rx_byte);
            if (rx_byte[CMD_RW_BIT]) begin
              state_n     = RD_REQ;
              reg_rd_en_n = 1'b1;
              reg_addr_n  = ADDR_W'(rx_byte);
            end else begin
              state_n = WR_STREAM;
            end
          end
        end
        RD_REQ: begin
          state_n = RD_WAIT;
          if (rx_ok) err_n = 1'b1;
        end
        RD_WAIT: begin
          state_n   = RD_STREAM;
          tx_byte_n = 8'(reg_rdata);
          tx_load_n = 1'b1;
          addr_n    = addr + 1'b1;
          if (rx_ok) err_n = 1'b1;
        end
        RD_STREAM: begin
          if (rx_ok) begin
            state_n     = RD_REQ;
            reg_rd_en_n = 1'b1;
            reg_addr_n  = addr;
          end
        end
        WR_STREAM: begin
          if (rx_ok) begin
            reg_wr_en_n = 1'b1;
            reg_addr_n  = addr;
            reg_wdata_n = DATA_W'(rx_byte);
            addr_n      = addr + 1'b1;
          end
        end
        DROP: begin
          state_n = DROP;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // cs_prev resets high so a chip select held through reset
  // does not look like a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cs_prev     <= 1'b1;
      tx_byte     <= DUMMY;
      tx_load     <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wdata   <= '0;
      reg_rd_en   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      cs_prev     <= cs_active;
      tx_byte     <= tx_byte_n;
      tx_load     <= tx_load_n;
      reg_addr    <= reg_addr_n;
      reg_wr_en   <= reg_wr_en_n;
      reg_wdata   <= reg_wdata_n;
      reg_rd_en   <= reg_rd_en_n;
      err_overrun <= err_n;
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Scoreboard bench for spi_reg_controller: transaction-level model
// predicts strobes and tx loads with their cycle of appearance.
module tb_spi_reg_controller;
  import spi_ctrl_pkg::*;

  localparam logic [7:0] DMY = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err_overrun;

  spi_reg_controller #(
    .ADDR_W(7),
    .DATA_W(8),
    .DUMMY (DMY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_active  (cs_active),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wdata  (reg_wdata),
    .reg_rd_en  (reg_rd_en),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 29 + 7);
  endfunction

  // Register file attached to the DUT: one-cycle read latency.
  logic [7:0] rf [128];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) rf[i] <= init_val(i);
      reg_rdata <= 8'h00;
    end else begin
      if (reg_wr_en) rf[reg_addr] <= reg_wdata;
      if (reg_rd_en) reg_rdata <= rf[reg_addr];
    end
  end

  int wr_cnt = 0;
  int rd_cnt = 0;
  int ld_cnt = 0;
  always @(posedge clk) begin
    if (reg_wr_en) wr_cnt++;
    if (reg_rd_en) rd_cnt++;
    if (tx_load) ld_cnt++;
  end

  typedef struct packed {
    logic [7:0]  kind;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [31:0] c;
  } ev_t;

  ev_t expq[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;

  function automatic ev_t mk(input int kind, input logic [7:0] a,
                             input logic [7:0] d, input int c);
    ev_t e;
    e.kind = 8'(kind);
    e.a    = a;
    e.d    = d;
    e.c    = 32'(c);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic match(input ev_t g);
    ev_t e;
    if (expq.size() == 0) begin
      total_cnt++;
      $display("FAIL unexpected_event: got %h, expected none", g);
    end else begin
      e = expq.pop_front();
      check("event", 64'(g), 64'(e));
    end
  endtask

  // Monitor: kind 0 = write, 1 = read strobe, 2 = tx load.
  always @(negedge clk) begin
    if (reg_wr_en || reg_rd_en)
      check("rw_exclusive", 64'(reg_wr_en & reg_rd_en), 64'd0);
    if (reg_wr_en) match(mk(0, {1'b0, reg_addr}, reg_wdata, cyc));
    if (reg_rd_en) match(mk(1, {1'b0, reg_addr}, 8'h00, cyc));
    if (tx_load) match(mk(2, 8'h00, tx_byte, cyc));
  end

  // Reference model at transaction level.
  logic [7:0] ref_mem [128];
  logic [6:0] m_addr;
  logic       m_rd;
  logic       m_cmd;

  task automatic mem_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic model_read(input int k);
    expq.push_back(mk(1, {1'b0, m_addr}, 8'h00, k + 1));
    expq.push_back(mk(2, 8'h00, ref_mem[m_addr], k + 3));
    m_addr++;
  endtask

  task automatic model_byte(input logic [7:0] b, input int k);
    if (m_cmd) begin
      m_cmd  = 1'b0;
      m_addr = b[6:0];
      m_rd   = b[7];
      if (m_rd) model_read(k);
    end else if (m_rd) begin
      model_read(k);
    end else begin
      expq.push_back(mk(0, {1'b0, m_addr}, b, k + 1));
      ref_mem[m_addr] = b;
      m_addr++;
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({tx_byte, tx_load, reg_wr_en, reg_rd_en, busy,
                err_overrun, reg_addr, reg_wdata});
  endfunction

  task automatic cs_up();
    cs_active = 1'b1;
    expq.push_back(mk(2, 8'h00, DMY, cyc + 1));
    m_cmd = 1'b1;
    @(negedge clk);
  endtask

  task automatic cs_down();
    cs_active = 1'b0;
    @(negedge clk);
    check("busy_after_cs_fall", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    model_byte(b, cyc);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   k;
    int   w0;
    int   r0;
    int   l0;
    int   n;
    logic rd;
    logic [6:0] a;
    ev_t  keep[$];

    mem_reset();
    m_cmd  = 1'b0;
    m_rd   = 1'b0;
    m_addr = 7'd0;
    repeat (3) @(negedge clk);
    check("reset_state", outs(), 64'({DMY, 5'b0, 7'b0, 8'b0}));
    rst = 1'b0;
    @(negedge clk);

    // Write burst 05, AA, BB
    w0 = wr_cnt;
    cs_up();
    check("busy_in_txn", 64'(busy), 64'd1);
    send(8'h05, 2);
    send(8'hAA, 2);
    send(8'hBB, 2);
    cs_down();
    check("write_count", 64'(wr_cnt - w0), 64'd2);

    // Preload 0x3C at address 5, then read it back
    cs_up();
    send(8'h05, 2);
    send(8'h3C, 2);
    cs_down();
    cs_up();
    send(8'h85, 2);
    #1;
    check("read_tx_load", 64'(tx_load), 64'd1);
    check("read_tx_byte", 64'(tx_byte), 64'h3C);
    @(negedge clk);
    cs_down();

    // Address wrap in a write burst
    cs_up();
    send(8'h7F, 2);
    send(8'h11, 2);
    send(8'h22, 2);
    cs_down();
    check("wrap_rf0", 64'(rf[0]), 64'h22);
    check("wrap_rf7f", 64'(rf[127]), 64'h11);

    // Overrun: second byte lands while the read is in flight
    r0 = rd_cnt;
    cs_up();
    k = cyc;
    model_byte(8'h85, k);
    rx_valid = 1'b1;
    rx_byte  = 8'h85;
    @(negedge clk);
    rx_byte = 8'h5A;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_set", 64'(err_overrun), 64'd1);
    check("overrun_one_read", 64'(rd_cnt - r0), 64'd1);
    cs_down();
    check("overrun_sticky", 64'(err_overrun), 64'd1);
    cs_up();
    check("overrun_clear", 64'(err_overrun), 64'd0);
    cs_down();

    // cs falls together with the second data byte
    cs_up();
    send(8'h10, 2);
    send(8'hCC, 2);
    w0 = wr_cnt;
    cs_active = 1'b0;
    rx_valid  = 1'b1;
    rx_byte   = 8'hDD;
    @(negedge clk);
    rx_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_write", 64'(wr_cnt - w0), 64'd0);

    // Bytes while cs is low are ignored
    l0 = wr_cnt + rd_cnt + ld_cnt;
    rx_valid = 1'b1;
    rx_byte  = 8'h81;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("cs_low_ignored", 64'(wr_cnt + rd_cnt + ld_cnt - l0), 64'd0);
    check("cs_low_idle", 64'(busy), 64'd0);

    // Reset in the middle of a read burst, cs held high
    cs_up();
    send(8'h90, 2);
    k = cyc;
    model_byte(8'h00, k);
    rx_valid = 1'b1;
    rx_byte  = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    keep.delete();
    foreach (expq[i]) if (int'(expq[i].c) < k + 2) keep.push_back(expq[i]);
    expq = keep;
    mem_reset();
    @(negedge clk);
    check("midburst_reset", outs(), 64'({DMY, 5'b0, 7'b0, 8'b0}));
    @(negedge clk);
    rst = 1'b0;
    #1;
    l0 = ld_cnt;
    @(negedge clk);
    repeat (8) @(negedge clk);
    check("no_load_after_reset", 64'(ld_cnt - l0), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
    cs_down();
    cs_up();
    send(8'h85, 2);
    cs_down();

    // Randomised bursts, some starting near the top address
    for (int t = 0; t < 16; t++) begin
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 7'h7D + 7'($urandom_range(0, 2));
      else a = 7'($urandom);
      n = $urandom_range(1, 4);
      cs_up();
      send({rd, a}, $urandom_range(2, 5));
      for (int j = 0; j < n; j++) send(8'($urandom), $urandom_range(2, 5));
      check("rand_no_overrun", 64'(err_overrun), 64'd0);
      cs_down();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
